otter_intr_ctrl: RTL and testbench
==================================

Name: otter_intr_ctrl

Overview:
- Interrupt controller that owns the source side of the OTTER CPU interrupt handshake.
- Collects NUM_SRC external interrupt lines, synchronizes them, latches rising edges as pending, and masks each source.
- Selects one request by fixed priority and drives the single `intr` line into the control-unit FSM.
- Consumes the FSM's `int_taken` and `mret_exec` acknowledgments to clear pending state and to bracket the in-service window.

Parameters:
- NUM_SRC, 4, number of external interrupt sources (2..16).
- SYNC_STAGES, 2, flip-flop stages in each input synchronizer (>=2).
- ID_W, $clog2(NUM_SRC), width of irq_id (derived localparam, not overridable).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- RST  input  1  reset, asynchronous, active-high; clears all state immediately.
- irq_in  input  NUM_SRC  raw asynchronous interrupt lines, active-high.
- irq_mask  input  NUM_SRC  per-source enable from the CSR file; 1 = enabled.
- mie  input  1  global interrupt enable (mstatus.MIE) from the CSR file.
- int_taken  input  1  CU pulse: the CU has entered its interrupt state.
- mret_exec  input  1  CU pulse: the CU is executing MRET.
- intr  output  1  registered interrupt request to the CU.
- irq_id  output  ID_W  index of the requested or in-service source; registered.
- irq_pending  output  NUM_SRC  current pending vector, readable by software.
- in_service  output  1  high from the cycle after int_taken until the cycle after mret_exec.

Behaviour:
- Reset (async, RST=1): synchronizer flops=0, edge-history=0, irq_pending=0, intr=0, irq_id=0, in_service=0, state=IDLE.
- Sync/edge: each irq_in bit passes through SYNC_STAGES flops. A rising edge on a synchronized bit sets irq_pending[i].
  - With SYNC_STAGES=2, irq_pending[i] is high 3 clocks after irq_in[i] is first sampled high.
- Set wins over clear: an edge on source i in the same cycle int_taken clears i leaves pending[i]=1.
- Eligible vector = irq_pending & irq_mask. Priority is fixed: lowest index wins.
- FSM states IDLE, REQ, SERVICE.
  - IDLE:
    - If mie=1 and eligible!=0: latch irq_id = lowest eligible index, go to REQ. intr=1 in the REQ cycle, so request latency is 1 clock after pending.
    - int_taken and mret_exec are ignored in IDLE.
  - REQ:
    - intr=1 and irq_id is held stable. A higher-priority source arriving later does not preempt.
    - int_taken=1: clear irq_pending[irq_id], set intr=0 and in_service=1 next cycle, go to SERVICE.
    - Otherwise, if mie=0 or irq_mask[irq_id]=0: withdraw the request (intr=0 next cycle), go to IDLE. The pending bit is retained.
    - int_taken has priority over withdrawal in the same cycle.
    - mret_exec in REQ is ignored.
  - SERVICE:
    - intr=0. No nesting. New edges still set pending bits.
    - mret_exec=1: in_service=0 next cycle, go to IDLE. Re-arbitration happens on the following clock.
    - int_taken in SERVICE is ignored, i.e. spurious.
- irq_pending bits for masked sources accumulate and never self-clear.
- A pending bit is cleared only by int_taken in REQ, or by RST.
- Reset mid-REQ or mid-SERVICE: immediate return to reset values. Pending edges are lost.

Optional Feature:
- Macro: INTC_LEVEL_MODE_EN.
- Defined (level mode):
  - irq_pending[i] equals the synchronized irq_in[i] level; there is no edge latching.
  - int_taken does not clear pending; the source must deassert its own line.
  - In SERVICE, a still-high line re-requests after mret_exec through IDLE.
  - Withdrawal in REQ also occurs when the line drops.
- Undefined (default): edge-latched behaviour exactly as in Behaviour.

Test Plan:
- Reset then irq_in=4'b0100, mask=4'hF, mie=1 -> irq_pending[2]=1 at +3 clk; intr=1, irq_id=2 at +4 clk; held until int_taken.
- In REQ, pulse int_taken -> next clk intr=0, in_service=1, irq_pending=4'b0000; pulse mret_exec -> next clk in_service=0, state IDLE.
- Sources 3 and 1 pending simultaneously, mask=4'hF -> irq_id=1 first. After int_taken+mret_exec -> irq_id=3 is requested 2 clk after mret.
- In REQ with irq_id=1, drop mie -> intr=0 next clk, irq_pending[1] still 1; restore mie -> intr=1 again with irq_id=1.
- Edge on source 0 in the same cycle int_taken clears source 0 -> irq_pending[0]=1 afterwards and re-requests after mret_exec.
- Assert RST asynchronously while in SERVICE with pending=4'b1010 -> all outputs 0 with no clock edge; no request after RST drops until a new edge arrives.

Source files
------------

// File: rtl/otter_intr_ctrl_if.sv
// Signal bundle between the interrupt controller (master) and the CU/CSR side (slave).
// Inputs come from the raw lines and the CSR file. Outputs go to the CU and to software.
interface otter_intr_ctrl_if #(
  parameter int NUM_SRC = 4
);
  localparam int ID_W = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0] irq_in;
  logic [NUM_SRC-1:0] irq_mask;
  logic               mie;
  logic               int_taken;
  logic               mret_exec;
  logic               intr;
  logic [ID_W-1:0]    irq_id;
  logic [NUM_SRC-1:0] irq_pending;
  logic               in_service;

  modport master (
    input  irq_in, irq_mask, mie, int_taken, mret_exec,
    output intr, irq_id, irq_pending, in_service
  );

  modport slave (
    output irq_in, irq_mask, mie, int_taken, mret_exec,
    input  intr, irq_id, irq_pending, in_service
  );
endinterface

// File: rtl/otter_intr_ctrl.sv
// Fixed-priority interrupt controller for the OTTER CU: intr rises 1 clk after pending and holds until int_taken.
// The request is withdrawn if mie or the mask drops. INTC_LEVEL_MODE_EN selects level-sensitive pending instead of edge latching.
module otter_intr_ctrl #(
  parameter int NUM_SRC     = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               RST,
  otter_intr_ctrl_if.master  bus
);
  localparam int ID_W = $clog2(NUM_SRC);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t             state, state_nxt;
  logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
  logic [NUM_SRC-1:0] sync_lvl;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] eligible;
  logic [ID_W-1:0]    id_q, id_nxt, low_id;
  logic               intr_q, intr_nxt;
  logic               srv_q, srv_nxt;
  logic               take;
  logic               line_drop;

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= bus.irq_in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign sync_lvl = sync_q[SYNC_STAGES-1];
  assign take     = (state == REQ) && bus.int_taken;

`ifdef INTC_LEVEL_MODE_EN
  // Pending tracks the line itself; the source clears it by deasserting.
  assign pending   = sync_lvl;
  assign line_drop = ~pending[id_q];
`else
  logic [NUM_SRC-1:0] hist_q;
  logic [NUM_SRC-1:0] pending_q;
  logic [NUM_SRC-1:0] clr_vec;

  assign clr_vec   = take ? (NUM_SRC'(1) << id_q) : '0;
  assign pending   = pending_q;
  assign line_drop = 1'b0;

  // A new edge in the same cycle as the clear leaves the bit set.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      hist_q    <= '0;
      pending_q <= '0;
    end else begin
      hist_q    <= sync_lvl;
      pending_q <= (pending_q & ~clr_vec) | (sync_lvl & ~hist_q);
    end
  end
`endif

  assign eligible = pending & bus.irq_mask;

  always_comb begin
    low_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) low_id = ID_W'(i);
    end
  end

  always_comb begin
    state_nxt = state;
    id_nxt    = id_q;
    intr_nxt  = intr_q;
    srv_nxt   = srv_q;
    case (state)
      IDLE: begin
        if (bus.mie && (|eligible)) begin
          id_nxt    = low_id;
          intr_nxt  = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (take) begin
          intr_nxt  = 1'b0;
          srv_nxt   = 1'b1;
          state_nxt = SERVICE;
        end else if (!bus.mie || !bus.irq_mask[id_q] || line_drop) begin
          intr_nxt  = 1'b0;
          state_nxt = IDLE;
        end
      end
      SERVICE: begin
        if (bus.mret_exec) begin
          srv_nxt   = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: begin
        intr_nxt  = 1'b0;
        srv_nxt   = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      id_q   <= '0;
      intr_q <= 1'b0;
      srv_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      id_q   <= id_nxt;
      intr_q <= intr_nxt;
      srv_q  <= srv_nxt;
    end
  end

  assign bus.intr        = intr_q;
  assign bus.irq_id      = id_q;
  assign bus.irq_pending = pending;
  assign bus.in_service  = srv_q;
endmodule

// File: tb/tb_otter_intr_ctrl.sv
// Bench for otter_intr_ctrl: directed scenarios plus randomized traffic checked by a queue-based scoreboard.
`timescale 1ns/1ps
module tb_otter_intr_ctrl;
  localparam int N  = 4;
  localparam int SS = 2;

  logic clk = 1'b0;
  logic rst;

  otter_intr_ctrl_if #(.NUM_SRC(N)) bus ();
  otter_intr_ctrl #(.NUM_SRC(N), .SYNC_STAGES(SS)) dut (
    .clk (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         intr;
    int         id;
    bit [N-1:0] pend;
    bit         srv;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: raw-line history, pending set, and request/service flags.
  bit [N-1:0] hq[$];
  bit [N-1:0] m_pend;
  bit         m_req;
  bit         m_srv;
  int         m_id;

  task automatic check(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lowest(bit [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic void model_reset();
    m_pend = '0;
    m_req  = 1'b0;
    m_srv  = 1'b0;
    m_id   = 0;
    hq.delete();
    for (int i = 0; i < SS + 1; i++) hq.push_back('0);
  endfunction

  function automatic void model_step(bit [N-1:0] lines, bit [N-1:0] mask, bit en,
                                     bit taken, bit mret);
    bit [N-1:0] rise;
    bit [N-1:0] clr;
    rise = hq[1] & ~hq[0];
    clr  = '0;
    if (m_req) begin
      if (taken) begin
        clr[m_id] = 1'b1;
        m_req = 1'b0;
        m_srv = 1'b1;
      end else if (!en || !mask[m_id]) begin
        m_req = 1'b0;
      end
    end else if (m_srv) begin
      if (mret) m_srv = 1'b0;
    end else if (en && ((m_pend & mask) != '0)) begin
      m_id  = lowest(m_pend & mask);
      m_req = 1'b1;
    end
    m_pend = (m_pend & ~clr) | rise;
    void'(hq.pop_front());
    hq.push_back(lines);
  endfunction

  always @(posedge clk) begin
    if (rst) model_reset();
    else model_step(bus.irq_in, bus.irq_mask, bus.mie, bus.int_taken, bus.mret_exec);
    sb.push_back('{m_req, m_id, m_pend, m_srv});
  end

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (!rst) begin
        check("sb_intr",        int'(bus.intr),        int'(e.intr));
        check("sb_irq_id",      int'(bus.irq_id),      e.id);
        check("sb_irq_pending", int'(bus.irq_pending), int'(e.pend));
        check("sb_in_service",  int'(bus.in_service),  int'(e.srv));
      end
    end
  end

  task automatic cyc(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic pulse_take();
    bus.int_taken = 1'b1;
    cyc();
    bus.int_taken = 1'b0;
  endtask

  task automatic pulse_mret();
    bus.mret_exec = 1'b1;
    cyc();
    bus.mret_exec = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    bus.irq_in    = '0;
    bus.irq_mask  = '1;
    bus.mie       = 1'b1;
    bus.int_taken = 1'b0;
    bus.mret_exec = 1'b0;
    cyc(2);
    check("rst_intr", int'(bus.intr), 0);
    check("rst_id",   int'(bus.irq_id), 0);
    check("rst_pend", int'(bus.irq_pending), 0);
    check("rst_srv",  int'(bus.in_service), 0);
    rst = 1'b0;
    cyc();

    // Single source: pending at +3, request at +4, held until taken.
    bus.irq_in = 4'b0100;
    cyc(3);
    check("t1_pend3", int'(bus.irq_pending), 4);
    check("t1_intr3", int'(bus.intr), 0);
    cyc();
    check("t1_intr4", int'(bus.intr), 1);
    check("t1_id4",   int'(bus.irq_id), 2);
    cyc(2);
    check("t1_hold", int'(bus.intr), 1);
    pulse_take();
    check("t1_take_intr", int'(bus.intr), 0);
    check("t1_take_srv",  int'(bus.in_service), 1);
    check("t1_take_pend", int'(bus.irq_pending), 0);
    pulse_mret();
    check("t1_mret_srv", int'(bus.in_service), 0);
    cyc();
    check("t1_idle_intr", int'(bus.intr), 0);
    bus.irq_in = '0;
    cyc(3);

    // Two simultaneous sources: lowest index first, the other 2 clk after mret.
    bus.irq_in = 4'b1010;
    cyc(4);
    check("t3_intr", int'(bus.intr), 1);
    check("t3_id",   int'(bus.irq_id), 1);
    check("t3_pend", int'(bus.irq_pending), 10);
    pulse_take();
    check("t3_pend_after", int'(bus.irq_pending), 8);
    pulse_mret();
    check("t3_mret_intr", int'(bus.intr), 0);
    cyc();
    check("t3_rearb_intr", int'(bus.intr), 1);
    check("t3_rearb_id",   int'(bus.irq_id), 3);
    pulse_take();
    pulse_mret();
    bus.irq_in = '0;
    cyc(3);

    // Withdrawal on mie drop, re-request on restore.
    bus.irq_in = 4'b0010;
    cyc(4);
    check("t4_id", int'(bus.irq_id), 1);
    bus.mie = 1'b0;
    cyc();
    check("t4_withdraw", int'(bus.intr), 0);
    check("t4_keep_pend", int'(bus.irq_pending), 2);
    bus.mie = 1'b1;
    cyc();
    check("t4_rereq_intr", int'(bus.intr), 1);
    check("t4_rereq_id",   int'(bus.irq_id), 1);
    pulse_take();
    pulse_mret();
    bus.irq_in = '0;
    cyc(3);

    // New edge on source 0 coincides with its clear.
    bus.irq_in = 4'b0001;
    cyc();
    bus.irq_in = 4'b0000;
    cyc();
    bus.irq_in = 4'b0001;
    cyc(2);
    check("t5_intr", int'(bus.intr), 1);
    check("t5_id",   int'(bus.irq_id), 0);
    pulse_take();
    check("t5_set_wins", int'(bus.irq_pending), 1);
    check("t5_srv",      int'(bus.in_service), 1);
    pulse_mret();
    cyc();
    check("t5_rereq_intr", int'(bus.intr), 1);
    check("t5_rereq_id",   int'(bus.irq_id), 0);
    pulse_take();
    pulse_mret();
    bus.irq_in = '0;
    cyc(3);

    // Asynchronous reset while in service with other sources pending.
    bus.irq_in = 4'b0001;
    cyc(4);
    pulse_take();
    bus.irq_in = 4'b1011;
    cyc(3);
    check("t6_pend", int'(bus.irq_pending), 10);
    check("t6_srv",  int'(bus.in_service), 1);
    #1;
    rst        = 1'b1;
    bus.irq_in = '0;
    #1;
    check("t6_arst_intr", int'(bus.intr), 0);
    check("t6_arst_id",   int'(bus.irq_id), 0);
    check("t6_arst_pend", int'(bus.irq_pending), 0);
    check("t6_arst_srv",  int'(bus.in_service), 0);
    cyc(2);
    rst = 1'b0;
    cyc(6);
    check("t6_quiet_intr", int'(bus.intr), 0);
    check("t6_quiet_pend", int'(bus.irq_pending), 0);
    bus.irq_in = 4'b1000;
    cyc(4);
    check("t6_new_intr", int'(bus.intr), 1);
    check("t6_new_id",   int'(bus.irq_id), 3);
    pulse_take();
    pulse_mret();

    // Randomized traffic, checked by the scoreboard.
    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 7) == 0) bus.irq_in[b] = ~bus.irq_in[b];
      if ($urandom_range(0, 15) == 0) bus.irq_mask = N'($urandom);
      bus.mie       = ($urandom_range(0, 9) != 0);
      bus.int_taken = ($urandom_range(0, 3) == 0);
      bus.mret_exec = ($urandom_range(0, 4) == 0);
      rst           = ($urandom_range(0, 299) == 0);
      cyc();
    end
    rst           = 1'b0;
    bus.int_taken = 1'b0;
    bus.mret_exec = 1'b0;
    cyc(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
